xswitch_in_arbiter: RTL and testbench
=====================================

// Module: xswitch_in_arbiter
// PURPOSE
// Round-robin arbiter sharing the single xswitch input port (data_in/addr_in/valid_in/rcv_rdy)
// among NUM_REQ requesters. Grants one requester at a time with bounded burst lock and
// registers the selected beat into a one-entry output stage that drives the switch input.
// Flags a sticky error when the switch stalls the input port for too long.
// PARAMETERS
// NUM_REQ    4   number of requesters (2..16)
// DATA_W     8   width of data_in / req_data lanes
// ADDR_W     4   width of addr_in / req_addr lanes
// MAX_BURST  4   max beats accepted from one grant before rotating (>=1)
// STALL_MAX  64  consecutive cycles of valid_in && !rcv_rdy that set stall_err
// PORTS
// clk        in   1                 single clock, all logic on rising edge
// reset      in   1                 asynchronous, active-low reset
// req_valid  in   NUM_REQ           requester i has a beat on its lane
// req_data   in   NUM_REQ*DATA_W    lane i = bits [i*DATA_W +: DATA_W]
// req_addr   in   NUM_REQ*ADDR_W    lane i = bits [i*ADDR_W +: ADDR_W]
// req_ready  out  NUM_REQ           one-hot (or 0); beat i accepted when req_valid[i]&&req_ready[i]
// valid_in   out  1                 to xswitch: output stage holds a beat
// data_in    out  DATA_W            to xswitch
// addr_in    out  ADDR_W            to xswitch
// rcv_rdy    in   1                 from xswitch: beat taken when valid_in && rcv_rdy
// grant_id   out  $clog2(NUM_REQ)   current/last granted requester
// busy       out  1                 FSM in SERVE or output stage occupied
// stall_err  out  1                 sticky: switch stalled input >= STALL_MAX cycles
// BEHAVIOUR
// - Reset (reset=0, async): valid_in=0, data_in=0, addr_in=0, req_ready=0, grant_id=0, busy=0,
//   stall_err=0, ptr=0, beat_cnt=0, FSM=IDLE. In-flight beat discarded; no beat is replayed.
// - Output stage: load_en = !valid_in || rcv_rdy. Beat held stable while valid_in && !rcv_rdy.
//   On load with no accepted beat, valid_in clears when the current one is taken.
// - req_ready[g] = (FSM==SERVE) && load_en; all other bits 0. Combinational from rcv_rdy.
// - Latency: beat accepted in cycle N appears on valid_in/data_in/addr_in in N+1.
//   Throughput 1 beat/cycle within a grant; 1 bubble cycle (IDLE) between grants.
// - FSM IDLE: if any req_valid, winner = first i with req_valid[i] searching ptr, ptr+1, ...
//   mod NUM_REQ; register g=winner, grant_id=winner, beat_cnt=0, go SERVE. Else stay.
// - FSM SERVE: each accepted beat increments beat_cnt. Exit to IDLE, with ptr=(g+1) mod
//   NUM_REQ, when: (a) beat accepted and beat_cnt==MAX_BURST-1, or (b) load_en && !req_valid[g].
//   While !load_en, stay in SERVE regardless of req_valid[g] (no grant loss under backpressure).
// - Fairness: any requester holding req_valid is granted within NUM_REQ-1 other grants.
// - Requester deasserting req_valid without a handshake is legal; lane value not sampled.
// - Stall counter: increments while valid_in && !rcv_rdy, clears on valid_in&&rcv_rdy or !valid_in;
//   saturates at STALL_MAX; stall_err set when count reaches STALL_MAX, cleared only by reset.
// - busy = (FSM==SERVE) || valid_in.
// - grant_id holds last winner in IDLE; wrap-around of ptr from NUM_REQ-1 to 0 is required.
// TESTING
// 1 Reset: drive reset=0 mid-burst with valid_in=1 -> all outputs 0 same cycle; after release
//   with req_valid=4'b0100 -> grant_id=2 one cycle later, valid_in=1 two cycles after release.
// 2 Round-robin: req_valid=4'b1111 constant, rcv_rdy=1, MAX_BURST=4 -> grants 0,1,2,3,0
//   each 4 beats, one idle cycle between, addr/data on xswitch match each lane in order.
// 3 Backpressure: rcv_rdy=0 for 5 cycles with valid_in=1, data 8'hA5 -> data_in stable 8'hA5,
//   req_ready=0, beat_cnt unchanged; next beat accepted in cycle rcv_rdy returns to 1.
// 4 Early release: requester 1 sends 2 beats then drops req_valid, req 3 pending ->
//   exit after 2 beats, next grant_id=3, requester 2 skipped (not valid).
// 5 Stall: hold rcv_rdy=0 with valid_in=1 for 64 cycles -> stall_err=1 at 64th cycle,
//   stays 1 after rcv_rdy=1 until reset.
// 6 Wrap: ptr=3 after grant to 2, req_valid=4'b0001 -> grant_id=0 (wrap), single beat passes.

Source files
------------

// File: rtl/xswitch_in_arbiter.sv
// xswitch_in_arbiter
// Shares the single xswitch input port among NUM_REQ requesters. Arbitration
// is round-robin, and a grant is held for at most MAX_BURST beats. The
// selected beat is registered into a one-entry output stage that drives the
// switch. A sticky error flags a switch that stalls the port for too long.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  per-requester beat valid
//   req_data   per-requester data lanes, lane i = [i*DATA_W +: DATA_W]
//   req_addr   per-requester address lanes, lane i = [i*ADDR_W +: ADDR_W]
//   req_ready  one-hot (or zero) accept, combinational from rcv_rdy
//   valid_in   output stage holds a beat for the switch
//   data_in    beat data to the switch
//   addr_in    beat address to the switch
//   rcv_rdy    switch takes the beat when valid_in && rcv_rdy
//   grant_id   current grant, or the last winner while idle
//   busy       serving a grant, or the output stage is occupied
//   stall_err  sticky: switch stalled the port for STALL_MAX cycles
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; pick the next requester round-robin from ptr
// SERVE | grant_id owns the port; beats pass while the stage can load

module xswitch_in_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int MAX_BURST = 4,
    parameter int STALL_MAX = 64,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       valid_in,
    output logic [DATA_W-1:0]          data_in,
    output logic [ADDR_W-1:0]          addr_in,
    input  logic                       rcv_rdy,
    output logic [GW-1:0]              grant_id,
    output logic                       busy,
    output logic                       stall_err
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t            state;
    logic [GW-1:0]     ptr;
    logic [BW-1:0]     beat_cnt;
    logic [SW-1:0]     stall_cnt;

    logic              load_en;
    logic              serving;
    logic              accept;
    logic              last_beat;
    logic              stalled;
    logic [GW-1:0]     next_ptr;
    logic [GW-1:0]     winner;
    logic              found;
    int                search_idx;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sel_addr;

    // The stage can take a new beat when it is empty or is being emptied
    // this cycle.
    assign load_en   = !valid_in || rcv_rdy;
    assign serving   = (state == SERVE);
    assign accept    = serving && load_en && req_valid[grant_id];
    assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
    assign stalled   = valid_in && !rcv_rdy;
    assign next_ptr  = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy      = serving || valid_in;

    always_comb begin
        req_ready = '0;
        if (serving && load_en) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_id) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner     = '0;
        found      = 1'b0;
        search_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = int'(ptr) + k;
            if (search_idx >= NUM_REQ) begin
                search_idx = search_idx - NUM_REQ;
            end
            if (!found && req_valid[search_idx]) begin
                found  = 1'b1;
                winner = GW'(search_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                        state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (accept) begin
                        if (last_beat) begin
                            ptr   <= next_ptr;
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (load_en) begin
                        // accept is false with load_en high only when the
                        // owner has dropped req_valid: give up the grant.
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output stage. Data holds while the switch stalls; when the
    // stage drains with nothing new accepted it simply goes empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_in <= 1'b0;
            data_in  <= '0;
            addr_in  <= '0;
        end else if (load_en) begin
            if (accept) begin
                valid_in <= 1'b1;
                data_in  <= sel_data;
                addr_in  <= sel_addr;
            end else begin
                valid_in <= 1'b0;
            end
        end
    end

    // stall_err rises on the same edge at which the count reaches STALL_MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (stalled) begin
            if (stall_cnt != SW'(STALL_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall_cnt >= SW'(STALL_MAX - 1)) begin
                stall_err <= 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_xswitch_in_arbiter.sv
module tb_xswitch_in_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MB = 4;
    localparam int SM = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR-1:0]     req_ready;
    logic              valid_in;
    logic [DW-1:0]     data_in;
    logic [AW-1:0]     addr_in;
    logic              rcv_rdy = 1'b1;
    logic [1:0]        grant_id;
    logic              busy;
    logic              stall_err;

    always #5 clk = ~clk;

    xswitch_in_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .STALL_MAX(SM)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_addr(req_addr), .req_ready(req_ready), .valid_in(valid_in),
        .data_in(data_in), .addr_in(addr_in), .rcv_rdy(rcv_rdy),
        .grant_id(grant_id), .busy(busy), .stall_err(stall_err)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] addr;
        logic [1:0] gid;
        int         gap;
    } beat_t;

    beat_t       sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          last_out = 0;
    bit          sb_en = 1'b0;
    int          remaining[NR];
    int          sent[NR];
    int          nxt[NR];
    logic [7:0]  dbase[NR];
    logic [NR-1:0] hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [7:0] data_of(input int i, input int n);
        return dbase[i] + 8'(n);
    endfunction

    function automatic logic [3:0] addr_of(input int i, input int n);
        return 4'(i * 3 + n + 1);
    endfunction

    task automatic drive_lanes();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (remaining[i] > 0);
            req_data[i*DW +: DW] = data_of(i, sent[i]);
            req_addr[i*AW +: AW] = addr_of(i, sent[i]);
        end
    endtask

    task automatic monitor();
        beat_t e;
        if (sb_en && valid_in && rcv_rdy) begin
            check("beat_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("beat_data", 32'(data_in), 32'(e.data));
                check("beat_addr", 32'(addr_in), 32'(e.addr));
                check("beat_gid", 32'(grant_id), 32'(e.gid));
                if (e.gap != 0) check("beat_gap", 32'(cycle - last_out), 32'(e.gap));
            end
            last_out = cycle;
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs and handshakes
    // are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        hs = req_valid & req_ready;
        monitor();
        @(posedge clk);
        cycle++;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                sent[i]++;
                remaining[i]--;
            end
        end
        drive_lanes();
    endtask

    task automatic sync_nxt();
        for (int i = 0; i < NR; i++) nxt[i] = sent[i];
    endtask

    task automatic push_burst(input int r, input int n, input int first_gap, input bit timed);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.data = data_of(r, nxt[r]);
            e.addr = addr_of(r, nxt[r]);
            e.gid  = 2'(r);
            e.gap  = !timed ? 0 : ((b == 0) ? first_gap : 1);
            nxt[r]++;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check("drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!valid_in && k < 10) begin
            tick();
            k++;
        end
        check(tag, 32'(valid_in), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_in), 32'd0);
        check({tag, "_data"}, 32'(data_in), 32'd0);
        check({tag, "_addr"}, 32'(addr_in), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_gid"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_stall"}, 32'(stall_err), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) remaining[i] = 0;
        sb_q.delete();
        rcv_rdy = 1'b1;
        drive_lanes();
        repeat (2) tick();
        reset = 1'b1;
        sync_nxt();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 0;
            sent[i] = 0;
            nxt[i] = 0;
            dbase[i] = 8'((i + 1) * 16);
        end
        drive_lanes();
        repeat (2) tick();
        check_zero("por");
        reset = 1'b1;

        // Reset mid-burst, then grant to requester 2 after release
        remaining[3] = 4;
        drive_lanes();
        wait_valid("pre_rst_valid");
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_zero("mid_rst");
        for (int i = 0; i < NR; i++) remaining[i] = 0;
        drive_lanes();
        repeat (2) tick();
        remaining[2] = 1;
        sync_nxt();
        push_burst(2, 1, 0, 1'b0);
        sb_en = 1'b1;
        reset = 1'b1;
        drive_lanes();
        tick();
        check("rel_gid", 32'(grant_id), 32'd2);
        check("rel_valid_early", 32'(valid_in), 32'd0);
        tick();
        check("rel_valid", 32'(valid_in), 32'd1);
        drain(20);
        check("idle_busy", 32'(busy), 32'd0);

        // Wrap: ptr is 3 after the grant to 2
        remaining[0] = 1;
        sync_nxt();
        push_burst(0, 1, 0, 1'b0);
        drive_lanes();
        tick();
        check("wrap_gid", 32'(grant_id), 32'd0);
        drain(20);

        // Round-robin with all requesters active; bubble between grants
        do_reset();
        remaining[0] = 8;
        remaining[1] = 4;
        remaining[2] = 4;
        remaining[3] = 4;
        push_burst(0, 4, 0, 1'b1);
        push_burst(1, 4, 2, 1'b1);
        push_burst(2, 4, 2, 1'b1);
        push_burst(3, 4, 2, 1'b1);
        push_burst(0, 4, 2, 1'b1);
        drive_lanes();
        drain(100);

        // Backpressure: beat count must not advance during the stall
        do_reset();
        dbase[1] = 8'hA5 - 8'(sent[1]);
        remaining[1] = 6;
        remaining[2] = 1;
        sync_nxt();
        push_burst(1, 4, 0, 1'b0);
        push_burst(2, 1, 0, 1'b0);
        push_burst(1, 2, 0, 1'b0);
        drive_lanes();
        wait_valid("bp_wait");
        check("bp_first", 32'(data_in), 32'hA5);
        rcv_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("bp_valid", 32'(valid_in), 32'd1);
            check("bp_data", 32'(data_in), 32'hA5);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        check("bp_no_accept", 32'(remaining[1]), 32'd5);
        rcv_rdy = 1'b1;
        #1;
        check("bp_resume_ready", 32'(req_ready), 32'b0010);
        drain(50);

        // Early release by requester 1; requester 2 skipped, 3 served
        do_reset();
        remaining[1] = 2;
        remaining[3] = 1;
        push_burst(1, 2, 0, 1'b1);
        push_burst(3, 1, 3, 1'b1);
        drive_lanes();
        drain(30);
        check("early_gid", 32'(grant_id), 32'd3);

        // Stall error after STALL_MAX stalled cycles, sticky until reset
        do_reset();
        remaining[0] = 1;
        push_burst(0, 1, 0, 1'b0);
        drive_lanes();
        wait_valid("stall_wait");
        rcv_rdy = 1'b0;
        repeat (SM - 1) tick();
        check("stall_before", 32'(stall_err), 32'd0);
        tick();
        check("stall_set", 32'(stall_err), 32'd1);
        rcv_rdy = 1'b1;
        drain(10);
        check("stall_sticky", 32'(stall_err), 32'd1);
        reset = 1'b0;
        #1;
        check("stall_reset", 32'(stall_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
